pipelined_shifter: RTL and testbench

Parametrised, pipelined barrel shifter for the ALU datapath. It supports four modes: logical left, logical right, arithmetic right and rotate left. There is one register stage per shift level (log2 WIDTH levels), and a valid/ready handshake runs on both sides. A user tag travels alongside each operation so the issuing logic can match results to requests.

---
 rtl/shifter_pkg.sv | 24 ++
 rtl/shift_stage.sv | 107 ++++++++++
 rtl/pipelined_shifter.sv | 80 ++++++++
 tb/tb_pipelined_shifter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// the helper that derives the shift-amount width from the data width.
package shifter_pkg;

   localparam logic [1:0] MODE_SLL = 2'b00;
   localparam logic [1:0] MODE_SRL = 2'b01;
   localparam logic [1:0] MODE_SRA = 2'b10;
   localparam logic [1:0] MODE_ROL = 2'b11;

   // Smallest w with 2**w >= width; for a power-of-two width this is log2(width).
   function automatic int shamt_width(input int width);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < width) begin
            w = i + 1;
         end else begin
            w = w;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One level of the barrel shifter: shifts by DIST when the matching shamt bit
// is set, then registers the result with its valid/shamt/mode/sign/tag fields.
// The stage advances when empty or when downstream takes its contents.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST = 1,
   parameter int TAG_W = 4,
   localparam int SHAMT_W = shamt_width(WIDTH)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               up_valid,
   output logic               up_ready,
   input  logic [WIDTH-1:0]   up_data,
   input  logic [SHAMT_W-1:0] up_shamt,
   input  logic [1:0]         up_mode,
   input  logic               up_sign,
   input  logic [TAG_W-1:0]   up_tag,
   output logic               dn_valid,
   input  logic               dn_ready,
   output logic [WIDTH-1:0]   dn_data,
   output logic [SHAMT_W-1:0] dn_shamt,
   output logic [1:0]         dn_mode,
   output logic               dn_sign,
   output logic [TAG_W-1:0]   dn_tag
);

   // Bit of shamt that this level is responsible for.
   localparam int K = shamt_width(DIST);

   logic               adv_s;
   logic [WIDTH-1:0]   shifted_s;
   logic [SHAMT_W-1:0] shamt_next_s;

   logic               valid_r;
   logic [WIDTH-1:0]   data_r;
   logic [SHAMT_W-1:0] shamt_r;
   logic [1:0]         mode_r;
   logic               sign_r;
   logic [TAG_W-1:0]   tag_r;

   // An empty stage always accepts, which lets bubbles collapse under stall.
   assign adv_s    = ~valid_r | dn_ready;
   assign up_ready = adv_s;

   // Apply this level's shift and retire the shamt bit it consumed.
   always_comb begin
      shifted_s    = up_data;
      shamt_next_s = up_shamt;
      shamt_next_s[K] = 1'b0;
      if (up_shamt[K]) begin
         case (up_mode)
            MODE_SLL: shifted_s = up_data << DIST;
            MODE_SRL: shifted_s = up_data >> DIST;
            MODE_SRA: shifted_s = {{DIST{up_sign}}, up_data[WIDTH-1:DIST]};
            MODE_ROL: shifted_s = (up_data << DIST) | (up_data >> (WIDTH - DIST));
            default:  shifted_s = up_data;
         endcase
      end else begin
         shifted_s = up_data;
      end
   end

   // Stage register: load on advance, hold every field while stalled.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid_r <= 1'b0;
         data_r  <= '0;
         shamt_r <= '0;
         mode_r  <= 2'b00;
         sign_r  <= 1'b0;
         tag_r   <= '0;
      end else if (adv_s) begin
         valid_r <= up_valid;
         if (up_valid) begin
            data_r  <= shifted_s;
            shamt_r <= shamt_next_s;
            mode_r  <= up_mode;
            sign_r  <= up_sign;
            tag_r   <= up_tag;
         end else begin
            data_r  <= data_r;
            shamt_r <= shamt_r;
            mode_r  <= mode_r;
            sign_r  <= sign_r;
            tag_r   <= tag_r;
         end
      end else begin
         valid_r <= valid_r;
         data_r  <= data_r;
         shamt_r <= shamt_r;
         mode_r  <= mode_r;
         sign_r  <= sign_r;
         tag_r   <= tag_r;
      end
   end

   assign dn_valid = valid_r;
   assign dn_data  = data_r;
   assign dn_shamt = shamt_r;
   assign dn_mode  = mode_r;
   assign dn_sign  = sign_r;
   assign dn_tag   = tag_r;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) registered shift levels chained with
// valid/ready handshakes. Supports SLL, SRL, SRA and ROL and carries a tag.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4,
   localparam int SHAMT_W = shamt_width(WIDTH)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               busy
);

   // Index 0 is the request side, index SHAMT_W is the last stage's register.
   logic [SHAMT_W:0]   valid_s;
   logic [SHAMT_W:0]   ready_s;
   logic [WIDTH-1:0]   data_s  [0:SHAMT_W];
   logic [SHAMT_W-1:0] shamt_s [0:SHAMT_W];
   logic [1:0]         mode_s  [0:SHAMT_W];
   logic [SHAMT_W:0]   sign_s;
   logic [TAG_W-1:0]   tag_s   [0:SHAMT_W];
   logic               unused_tail_s;

   assign valid_s[0] = in_valid;
   assign data_s[0]  = in_data;
   assign shamt_s[0] = in_shamt;
   assign mode_s[0]  = in_mode;
   // The operand MSB is captured once here and carried for SRA fill.
   assign sign_s[0]  = in_data[WIDTH-1];
   assign tag_s[0]   = in_tag;
   assign in_ready   = ready_s[0];

   assign ready_s[SHAMT_W] = out_ready;

   genvar k;
   for (k = 0; k < SHAMT_W; k++) begin : g_stage
      shift_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << k),
         .TAG_W (TAG_W)
      ) u_stage (
         .clock    (clock),
         .reset_n  (reset_n),
         .up_valid (valid_s[k]),
         .up_ready (ready_s[k]),
         .up_data  (data_s[k]),
         .up_shamt (shamt_s[k]),
         .up_mode  (mode_s[k]),
         .up_sign  (sign_s[k]),
         .up_tag   (tag_s[k]),
         .dn_valid (valid_s[k+1]),
         .dn_ready (ready_s[k+1]),
         .dn_data  (data_s[k+1]),
         .dn_shamt (shamt_s[k+1]),
         .dn_mode  (mode_s[k+1]),
         .dn_sign  (sign_s[k+1]),
         .dn_tag   (tag_s[k+1])
      );
   end

   assign out_valid = valid_s[SHAMT_W];
   assign out_data  = data_s[SHAMT_W];
   assign out_tag   = tag_s[SHAMT_W];
   assign busy      = |valid_s[SHAMT_W:1];

   // The last stage's shamt/mode/sign have no consumer past the pipeline.
   assign unused_tail_s = ^{shamt_s[SHAMT_W], mode_s[SHAMT_W], sign_s[SHAMT_W]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: a 32-bit and an 8-bit instance,
// queued stimulus, a whole-shift reference model and decoupled monitors.
module tb_pipelined_shifter;

   typedef struct {
      logic [31:0] data;
      int          shamt;
      logic [1:0]  mode;
      logic [3:0]  tag;
      bit          lat;
   } op_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  tag;
      int          acc;
      bit          lat;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
   logic [31:0] a_in_data, a_out_data;
   logic [4:0]  a_in_shamt;
   logic [1:0]  a_in_mode;
   logic [3:0]  a_in_tag, a_out_tag;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
   logic [7:0]  b_in_data, b_out_data;
   logic [2:0]  b_in_shamt;
   logic [1:0]  b_in_mode;
   logic [3:0]  b_in_tag, b_out_tag;

   pipelined_shifter #(.WIDTH(32), .TAG_W(4)) dut_a (
      .clock(clk), .reset_n(reset_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .in_shamt(a_in_shamt), .in_mode(a_in_mode), .in_tag(a_in_tag),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_tag(a_out_tag), .busy(a_busy)
   );

   pipelined_shifter #(.WIDTH(8), .TAG_W(4)) dut_b (
      .clock(clk), .reset_n(reset_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .in_shamt(b_in_shamt), .in_mode(b_in_mode), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_tag(b_out_tag), .busy(b_busy)
   );

   op_t  sa[$], sb[$];
   exp_t ea[$], eb[$];
   exp_t tmp_a, tmp_b;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_a = 0;
   int   acc_b = 0;
   bit   rnd_a = 1'b0;
   bit   rnd_b = 1'b0;

   bit          a_prev_stall = 1'b0, b_prev_stall = 1'b0;
   bit          a_shown = 1'b0, b_shown = 1'b0;
   logic [31:0] a_prev_data;
   logic [7:0]  b_prev_data;
   logic [3:0]  a_prev_tag, b_prev_tag;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model: whole shift by s in one step.
   function automatic logic [31:0] ref32(input logic [31:0] d, input int s, input logic [1:0] m);
      logic signed [31:0] sd;
      sd = d;
      case (m)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return sd >>> s;
         default: return (s == 0) ? d : ((d << s) | (d >> (32 - s)));
      endcase
   endfunction

   function automatic logic [7:0] ref8(input logic [7:0] d, input int s, input logic [1:0] m);
      logic signed [7:0] sd;
      sd = d;
      case (m)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return sd >>> s;
         default: return (s == 0) ? d : ((d << s) | (d >> (8 - s)));
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_a(input logic [31:0] d, input int s, input logic [1:0] m,
                         input logic [3:0] t, input bit lat);
      op_t o;
      o.data = d; o.shamt = s; o.mode = m; o.tag = t; o.lat = lat;
      sa.push_back(o);
   endtask

   task automatic push_b(input logic [7:0] d, input int s, input logic [1:0] m,
                         input logic [3:0] t, input bit lat);
      op_t o;
      o.data = {24'h0, d}; o.shamt = s; o.mode = m; o.tag = t; o.lat = lat;
      sb.push_back(o);
   endtask

   task automatic drain_a(input int limit);
      int n = 0;
      while ((sa.size() > 0 || ea.size() > 0) && n < limit) begin
         tick();
         n++;
      end
      check("a_drain_timeout", 64'(sa.size() + ea.size()), 64'd0);
   endtask

   task automatic drain_b(input int limit);
      int n = 0;
      while ((sb.size() > 0 || eb.size() > 0) && n < limit) begin
         tick();
         n++;
      end
      check("b_drain_timeout", 64'(sb.size() + eb.size()), 64'd0);
   endtask

   // Driver A: present queue head after each edge, record accepted ops.
   initial begin
      a_in_valid = 1'b0; a_in_data = 32'h0; a_in_shamt = 5'd0; a_in_mode = 2'b00; a_in_tag = 4'h0;
      forever begin
         @(posedge clk);
         #1;
         if (sa.size() > 0) begin
            a_in_valid = 1'b1;
            a_in_data  = sa[0].data;
            a_in_shamt = 5'(sa[0].shamt);
            a_in_mode  = sa[0].mode;
            a_in_tag   = sa[0].tag;
         end else begin
            a_in_valid = 1'b0;
         end
         @(negedge clk);
         if (reset_n && a_in_valid && a_in_ready) begin
            tmp_a.data = ref32(sa[0].data, sa[0].shamt, sa[0].mode);
            tmp_a.tag  = sa[0].tag;
            tmp_a.acc  = cyc;
            tmp_a.lat  = sa[0].lat;
            ea.push_back(tmp_a);
            void'(sa.pop_front());
            acc_a++;
         end
      end
   end

   // Driver B.
   initial begin
      b_in_valid = 1'b0; b_in_data = 8'h0; b_in_shamt = 3'd0; b_in_mode = 2'b00; b_in_tag = 4'h0;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            b_in_valid = 1'b1;
            b_in_data  = sb[0].data[7:0];
            b_in_shamt = 3'(sb[0].shamt);
            b_in_mode  = sb[0].mode;
            b_in_tag   = sb[0].tag;
         end else begin
            b_in_valid = 1'b0;
         end
         @(negedge clk);
         if (reset_n && b_in_valid && b_in_ready) begin
            tmp_b.data = {24'h0, ref8(sb[0].data[7:0], sb[0].shamt, sb[0].mode)};
            tmp_b.tag  = sb[0].tag;
            tmp_b.acc  = cyc;
            tmp_b.lat  = sb[0].lat;
            eb.push_back(tmp_b);
            void'(sb.pop_front());
            acc_b++;
         end
      end
   end

   // Random backpressure when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rnd_a) a_out_ready = ($urandom_range(3) != 0);
         if (rnd_b) b_out_ready = ($urandom_range(3) != 0);
      end
   end

   // Monitor A: stability under stall, latency, and in-order compare on transfer.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            a_prev_stall = 1'b0;
         end else begin
            if (a_prev_stall) begin
               check("a_stall_valid", 64'(a_out_valid), 64'd1);
               check("a_stall_data", 64'(a_out_data), 64'(a_prev_data));
               check("a_stall_tag", 64'(a_out_tag), 64'(a_prev_tag));
            end
            if (a_out_valid) begin
               if (ea.size() == 0) begin
                  check("a_unexpected_valid", 64'(a_out_valid), 64'd0);
               end else begin
                  if (!a_shown && ea[0].lat) check("a_latency", 64'(cyc - ea[0].acc), 64'd5);
                  a_shown = 1'b1;
                  if (a_out_ready) begin
                     check("a_data", 64'(a_out_data), 64'(ea[0].data));
                     check("a_tag", 64'(a_out_tag), 64'(ea[0].tag));
                     void'(ea.pop_front());
                     a_shown = 1'b0;
                  end
               end
            end
            a_prev_stall = a_out_valid && !a_out_ready;
            a_prev_data  = a_out_data;
            a_prev_tag   = a_out_tag;
         end
      end
   end

   // Monitor B.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            b_prev_stall = 1'b0;
         end else begin
            if (b_prev_stall) begin
               check("b_stall_valid", 64'(b_out_valid), 64'd1);
               check("b_stall_data", 64'(b_out_data), 64'(b_prev_data));
               check("b_stall_tag", 64'(b_out_tag), 64'(b_prev_tag));
            end
            if (b_out_valid) begin
               if (eb.size() == 0) begin
                  check("b_unexpected_valid", 64'(b_out_valid), 64'd0);
               end else begin
                  if (!b_shown && eb[0].lat) check("b_latency", 64'(cyc - eb[0].acc), 64'd3);
                  b_shown = 1'b1;
                  if (b_out_ready) begin
                     check("b_data", 64'(b_out_data), 64'(eb[0].data));
                     check("b_tag", 64'(b_out_tag), 64'(eb[0].tag));
                     void'(eb.pop_front());
                     b_shown = 1'b0;
                  end
               end
            end
            b_prev_stall = b_out_valid && !b_out_ready;
            b_prev_data  = b_out_data;
            b_prev_tag   = b_out_tag;
         end
      end
   end

   // Main sequence.
   initial begin
      int base;
      reset_n = 1'b0;
      a_out_ready = 1'b0;
      b_out_ready = 1'b0;
      repeat (3) tick();
      check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
      check("rst_a_out_data", 64'(a_out_data), 64'd0);
      check("rst_a_out_tag", 64'(a_out_tag), 64'd0);
      check("rst_a_busy", 64'(a_busy), 64'd0);
      check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
      check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
      check("rst_b_busy", 64'(b_busy), 64'd0);
      check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
      reset_n = 1'b1;
      tick();

      // Directed 32-bit ops, back-to-back, no backpressure, latency checked.
      a_out_ready = 1'b1;
      push_a(32'h0000_0001, 31, 2'b00, 4'd3, 1'b1);
      push_a(32'h8000_0000, 4, 2'b01, 4'd4, 1'b1);
      push_a(32'h8000_0000, 4, 2'b10, 4'd5, 1'b1);
      push_a(32'h7FFF_FFFF, 31, 2'b10, 4'd6, 1'b1);
      push_a(32'h8000_0001, 1, 2'b11, 4'd7, 1'b1);
      for (int m = 0; m < 4; m++) push_a(32'hDEAD_BEEF, 0, 2'(m), 4'(8 + m), 1'b1);
      push_a(32'hFFFF_FFF0, 31, 2'b10, 4'd12, 1'b1);
      drain_a(200);
      check("a_idle_busy", 64'(a_busy), 64'd0);
      check("a_idle_in_ready", 64'(a_in_ready), 64'd1);

      // Backpressure: 7 offered with the consumer stalled.
      a_out_ready = 1'b0;
      for (int t = 0; t < 7; t++) push_a($urandom, $urandom_range(31), 2'($urandom_range(3)), 4'(t), 1'b0);
      base = acc_a;
      repeat (8) tick();
      check("bp_accepted", 64'(acc_a - base), 64'd5);
      check("bp_in_ready", 64'(a_in_ready), 64'd0);
      check("bp_busy", 64'(a_busy), 64'd1);
      a_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check("bp_consecutive_valid", 64'(a_out_valid), 64'd1);
      end
      drain_a(200);

      // Reset with three operations in flight.
      push_a(32'h1234_5678, 3, 2'b00, 4'd1, 1'b0);
      push_a(32'h8765_4321, 7, 2'b10, 4'd2, 1'b0);
      push_a(32'hCAFE_F00D, 9, 2'b11, 4'd3, 1'b0);
      repeat (4) tick();
      check("mid_busy_before_reset", 64'(a_busy), 64'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      sa.delete(); ea.delete(); a_shown = 1'b0;
      sb.delete(); eb.delete(); b_shown = 1'b0;
      @(negedge clk);
      #1;
      check("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
      check("mid_rst_busy", 64'(a_busy), 64'd0);
      check("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
      check("mid_rst_out_data", 64'(a_out_data), 64'd0);
      check("mid_rst_out_tag", 64'(a_out_tag), 64'd0);
      repeat (12) tick();

      // Random 32-bit traffic with random backpressure.
      rnd_a = 1'b1;
      for (int i = 0; i < 1000; i++)
         push_a($urandom, $urandom_range(31), 2'($urandom_range(3)), 4'($urandom_range(15)), 1'b0);
      drain_a(20000);
      rnd_a = 1'b0;
      a_out_ready = 1'b1;

      // 8-bit instance: directed SRA, then random traffic.
      b_out_ready = 1'b1;
      push_b(8'h90, 3, 2'b10, 4'd9, 1'b1);
      push_b(8'h81, 7, 2'b11, 4'd10, 1'b1);
      push_b(8'hA5, 0, 2'b01, 4'd11, 1'b1);
      drain_b(100);
      rnd_b = 1'b1;
      for (int i = 0; i < 10000; i++)
         push_b(8'($urandom), $urandom_range(7), 2'($urandom_range(3)), 4'($urandom_range(15)), 1'b0);
      drain_b(60000);
      rnd_b = 1'b0;
      b_out_ready = 1'b1;
      repeat (4) tick();
      check("b_idle_busy", 64'(b_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
